cr_osf_ib_arb: RTL and testbench
================================

Name: cr_osf_ib_arb

Overview:
- Frame-atomic arbiter that merges the two OSF inbound AXI4-stream sources onto the single OSF core inbound port.
- Source 0 is the main data path; source 1 is the compression-guarantee (CG) path.
- Arbitration is weighted round-robin at frame granularity. Grant is held until the tlast beat of the current frame.
- Output is registered (one pipeline stage). The block also emits per-frame stat strobes.

Parameters:
- DATA_W, 64, tdata width in bits
- USER_W, 8, tuser width in bits
- WGT_W, 4, width of the source-0 weight config

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ib0_tvalid / ib0_tlast  in  1 each  source 0 valid / last
- ib0_tdata  in  DATA_W  source 0 data
- ib0_tuser  in  USER_W  source 0 user
- ib0_tstrb  in  DATA_W/8  source 0 byte strobes
- ib0_tready  out  1  source 0 ready
- ib1_tvalid, ib1_tlast, ib1_tdata, ib1_tuser, ib1_tstrb  in  (as ib0)  source 1 (CG) stream
- ib1_tready  out  1  source 1 ready
- ob_tvalid / ob_tlast  out  1 each  merged output valid / last
- ob_tdata  out  DATA_W  merged output data
- ob_tuser  out  USER_W  merged output user
- ob_tstrb  out  DATA_W/8  merged output strobes
- ob_tready  in  1  downstream ready
- cfg_ib0_weight  in  WGT_W  consecutive source-0 frames allowed under contention; 0 is treated as 1
- halt_i  in  1  request to stop granting new frames
- halted_o  out  1  arbiter idle and halted
- frame_done_stb  out  1  one-cycle pulse when an output tlast beat is accepted
- frame_done_src  out  1  source of the completed frame; valid while frame_done_stb is high

Behaviour:
- Reset: all outputs are 0, FSM = IDLE, rr_ptr = 0, wcnt = 0, output register empty.
- Reset is async on assertion and applies at any time. A frame in flight is abandoned with no flush; upstream and downstream are reset together.
- FSM states: IDLE, XFER0, XFER1.
- In IDLE, both ibN_tready are 0. The grant decision is registered, so there is one bubble cycle between frames.
- IDLE, grant eligible (not halted):
  - Only ib0_tvalid set -> XFER0, wcnt unchanged.
  - Only ib1_tvalid set -> XFER1, wcnt = 0.
  - Both set and wcnt < max(cfg_ib0_weight, 1) -> XFER0, wcnt += 1 (saturating).
  - Both set otherwise -> XFER1, wcnt = 0.
  - Neither set -> stay in IDLE.
- XFERn:
  - ibn_tready = !ob_tvalid | ob_tready. The other source's tready is 0.
  - An accepted beat (tvalid & tready) loads the output register with tdata, tuser, tstrb and tlast.
  - Accepting a tlast beat -> IDLE in the next cycle.
- Output register:
  - ob_tvalid is set on load.
  - It clears when ob_tready is high and no new load occurs in the same cycle.
  - Simultaneous drain and load keeps ob_tvalid = 1 with the new data.
  - Input-to-output latency is 1 cycle. Full throughput of 1 beat/cycle within a frame.
- frame_done_stb = ob_tvalid & ob_tready & ob_tlast. frame_done_src is a registered copy of the source that loaded that beat.
- cfg_ib0_weight is sampled only in IDLE. A change mid-frame takes effect at the next decision.
- A single-beat frame (tlast on the first beat) is legal: XFERn lasts 1 cycle when ob_tready is high.
- ob_tready held low: the output register holds its data, ibn_tready drops to 0, and the FSM stays in XFERn. No beat is lost or duplicated.

Optional Feature:
- Macro: CR_OSF_IB_ARB_HALT_EN.
- Defined:
  - halt_i high in IDLE suppresses all grants.
  - halt_i high in XFERn lets the current frame finish, then the FSM stays in IDLE.
  - halted_o = halt_i & (state == IDLE) & !ob_tvalid, registered.
  - Releasing halt_i resumes arbitration on the next cycle with wcnt preserved.
- Not defined: halt_i is ignored and halted_o is tied to 0.

Test Plan:
- ib0 sends a 4-beat frame alone with ob_tready = 1 -> ob shows the 4 beats starting 2 cycles after ib0_tvalid; frame_done_stb pulses once with src = 0.
- Both sources continuously valid with 1-beat frames, cfg_ib0_weight = 3 -> output frame source order is 0,0,0,1,0,0,0,1.
- Same contention with cfg_ib0_weight = 0 -> strict alternation 0,1,0,1.
- Mid-frame ob_tready toggles 1,0,0,1 on a 5-beat ib1 frame -> exactly 5 output beats in order, tready backpressure is seen upstream, and ib0 is never granted mid-frame.
- Assert rst_n low during beat 2 of a 4-beat frame -> all outputs are 0 immediately; after release the FSM is in IDLE and the next frame arbitrates fresh (wcnt = 0).
- CR_OSF_IB_ARB_HALT_EN defined, halt_i raised during beat 1 of a 3-beat ib0 frame with ib1 pending -> the ib0 frame completes, halted_o = 1 after drain, and no ib1 grant occurs; on halt_i release, ib1 is granted next.

Source files
------------

// File: rtl/cr_osf_ib_arb_if.sv
// Stream bundle for the OSF inbound arbiter: two AXI4-stream sources and the merged output.
// slave = arbiter side, master = traffic side (sources and downstream sink).
interface cr_osf_ib_arb_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned USER_W = 8
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              ib0_tvalid;
  logic              ib0_tlast;
  logic [DATA_W-1:0] ib0_tdata;
  logic [USER_W-1:0] ib0_tuser;
  logic [STRB_W-1:0] ib0_tstrb;
  logic              ib0_tready;

  logic              ib1_tvalid;
  logic              ib1_tlast;
  logic [DATA_W-1:0] ib1_tdata;
  logic [USER_W-1:0] ib1_tuser;
  logic [STRB_W-1:0] ib1_tstrb;
  logic              ib1_tready;

  logic              ob_tvalid;
  logic              ob_tlast;
  logic [DATA_W-1:0] ob_tdata;
  logic [USER_W-1:0] ob_tuser;
  logic [STRB_W-1:0] ob_tstrb;
  logic              ob_tready;

  modport slave (
    input  ib0_tvalid, ib0_tlast, ib0_tdata, ib0_tuser, ib0_tstrb,
    output ib0_tready,
    input  ib1_tvalid, ib1_tlast, ib1_tdata, ib1_tuser, ib1_tstrb,
    output ib1_tready,
    output ob_tvalid, ob_tlast, ob_tdata, ob_tuser, ob_tstrb,
    input  ob_tready
  );

  modport master (
    output ib0_tvalid, ib0_tlast, ib0_tdata, ib0_tuser, ib0_tstrb,
    input  ib0_tready,
    output ib1_tvalid, ib1_tlast, ib1_tdata, ib1_tuser, ib1_tstrb,
    input  ib1_tready,
    input  ob_tvalid, ob_tlast, ob_tdata, ob_tuser, ob_tstrb,
    output ob_tready
  );
endinterface

// File: rtl/cr_osf_ib_arb.sv
// Frame-atomic weighted round-robin merge of the OSF main (src 0) and CG (src 1) inbound streams.
// Optional halt support is enabled with `define CR_OSF_IB_ARB_HALT_EN.
module cr_osf_ib_arb #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned USER_W = 8,
  parameter int unsigned WGT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  cr_osf_ib_arb_if.slave   bus,
  input  logic [WGT_W-1:0] cfg_ib0_weight,
  input  logic             halt_i,
  output logic             halted_o,
  output logic             frame_done_stb,
  output logic             frame_done_src
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, XFER0, XFER1} state_e;

  state_e            state_q, state_d;
  logic [WGT_W-1:0]  wcnt_q, wcnt_d;
  logic [WGT_W-1:0]  wgt_max;
  logic              halt_act;
  logic              out_free;
  logic              ib0_rdy, ib1_rdy;
  logic              ld0, ld1;

  logic              ob_tvalid_q;
  logic              ob_tlast_q;
  logic [DATA_W-1:0] ob_tdata_q;
  logic [USER_W-1:0] ob_tuser_q;
  logic [STRB_W-1:0] ob_tstrb_q;
  logic              ob_src_q;

`ifdef CR_OSF_IB_ARB_HALT_EN
  logic halted_q;

  assign halt_act = halt_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halt_i & (state_q == IDLE) & ~ob_tvalid_q;
  end

  assign halted_o = halted_q;
`else
  logic unused_halt;

  assign unused_halt = halt_i;
  assign halt_act    = 1'b0;
  assign halted_o    = 1'b0;
`endif

  // A zero weight still lets source 0 win one contended frame.
  assign wgt_max  = (cfg_ib0_weight == '0) ? WGT_W'(1) : cfg_ib0_weight;
  assign out_free = ~ob_tvalid_q | bus.ob_tready;

  // Frame-granular grant decision and per-source ready.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ib0_rdy = 1'b0;
    ib1_rdy = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!halt_act) begin
          if (bus.ib0_tvalid && bus.ib1_tvalid) begin
            if (wcnt_q < wgt_max) begin
              state_d = XFER0;
              wcnt_d  = (wcnt_q == '1) ? wcnt_q : wcnt_q + WGT_W'(1);
            end else begin
              state_d = XFER1;
              wcnt_d  = '0;
            end
          end else if (bus.ib0_tvalid) begin
            state_d = XFER0;
          end else if (bus.ib1_tvalid) begin
            state_d = XFER1;
            wcnt_d  = '0;
          end
        end
      end
      XFER0: begin
        ib0_rdy = out_free;
        if (bus.ib0_tvalid && out_free && bus.ib0_tlast) state_d = IDLE;
      end
      XFER1: begin
        ib1_rdy = out_free;
        if (bus.ib1_tvalid && out_free && bus.ib1_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign ld0 = ib0_rdy & bus.ib0_tvalid;
  assign ld1 = ib1_rdy & bus.ib1_tvalid;

  // Single-stage output register; a drain and a load in the same cycle keep it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_tvalid_q <= 1'b0;
      ob_tlast_q  <= 1'b0;
      ob_tdata_q  <= '0;
      ob_tuser_q  <= '0;
      ob_tstrb_q  <= '0;
      ob_src_q    <= 1'b0;
    end else if (ld0 || ld1) begin
      ob_tvalid_q <= 1'b1;
      ob_tlast_q  <= ld1 ? bus.ib1_tlast : bus.ib0_tlast;
      ob_tdata_q  <= ld1 ? bus.ib1_tdata : bus.ib0_tdata;
      ob_tuser_q  <= ld1 ? bus.ib1_tuser : bus.ib0_tuser;
      ob_tstrb_q  <= ld1 ? bus.ib1_tstrb : bus.ib0_tstrb;
      ob_src_q    <= ld1;
    end else if (bus.ob_tready) begin
      ob_tvalid_q <= 1'b0;
    end
  end

  assign bus.ib0_tready = ib0_rdy;
  assign bus.ib1_tready = ib1_rdy;
  assign bus.ob_tvalid  = ob_tvalid_q;
  assign bus.ob_tlast   = ob_tlast_q;
  assign bus.ob_tdata   = ob_tdata_q;
  assign bus.ob_tuser   = ob_tuser_q;
  assign bus.ob_tstrb   = ob_tstrb_q;

  assign frame_done_stb = ob_tvalid_q & bus.ob_tready & ob_tlast_q;
  assign frame_done_src = ob_src_q;
endmodule

// File: tb/tb_cr_osf_ib_arb.sv
// Directed bench for cr_osf_ib_arb: queue-driven sources, output capture, hand-derived expectations.
module tb_cr_osf_ib_arb;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned USER_W = 8;
  localparam int unsigned WGT_W  = 4;

  typedef struct packed {
    logic [7:0]  strb;
    logic [7:0]  user;
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WGT_W-1:0] cfg_ib0_weight;
  logic             halt_i;
  logic             halted_o;
  logic             frame_done_stb;
  logic             frame_done_src;

  beat_t q0[$];
  beat_t q1[$];
  beat_t out_q[$];
  logic  stb_q[$];
  bit    f0, f1;
  bit    watch_mid = 1'b0;
  int    mid_ib0 = 0;
  int    saw_bp = 0;
  int    n_vec = 0;
  int    n_err = 0;

  cr_osf_ib_arb_if #(.DATA_W(DATA_W), .USER_W(USER_W)) bus ();

  cr_osf_ib_arb #(.DATA_W(DATA_W), .USER_W(USER_W), .WGT_W(WGT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .cfg_ib0_weight (cfg_ib0_weight),
    .halt_i         (halt_i),
    .halted_o       (halted_o),
    .frame_done_stb (frame_done_stb),
    .frame_done_src (frame_done_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic src, input int id, input int b, input int n);
    beat_t r;
    r.data = 32'({src, 8'(id), 8'(b)});
    r.user = {src, 7'(id)};
    r.strb = 8'hFF >> b;
    r.last = (b == n - 1);
    return r;
  endfunction

  task automatic drive_srcs();
    beat_t h0, h1;
    h0 = '0;
    h1 = '0;
    if (q0.size() > 0) h0 = q0[0];
    if (q1.size() > 0) h1 = q1[0];
    bus.ib0_tvalid = (q0.size() > 0);
    bus.ib0_tdata  = 64'(h0.data);
    bus.ib0_tuser  = h0.user;
    bus.ib0_tstrb  = h0.strb;
    bus.ib0_tlast  = h0.last;
    bus.ib1_tvalid = (q1.size() > 0);
    bus.ib1_tdata  = 64'(h1.data);
    bus.ib1_tuser  = h1.user;
    bus.ib1_tstrb  = h1.strb;
    bus.ib1_tlast  = h1.last;
  endtask

  task automatic push_frame(input logic src, input int id, input int n);
    for (int b = 0; b < n; b++) begin
      if (src) q1.push_back(mk(1'b1, id, b, n));
      else     q0.push_back(mk(1'b0, id, b, n));
    end
    drive_srcs();
  endtask

  task automatic clr();
    out_q.delete();
    stb_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || bus.ob_tvalid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(n < 300), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string tag, input int idx0, input logic src, input int id, input int n);
    for (int b = 0; b < n; b++) begin
      if (idx0 + b < out_q.size()) chk(tag, 64'(out_q[idx0 + b]), 64'(mk(src, id, b, n)));
      else                         chk({tag, "_missing"}, 64'(out_q.size()), 64'(idx0 + b + 1));
    end
  endtask

  // Source handshakes are observed mid-cycle and retired just after the edge.
  always begin
    @(negedge clk);
    f0 = bus.ib0_tvalid & bus.ib0_tready;
    f1 = bus.ib1_tvalid & bus.ib1_tready;
    @(posedge clk); #1;
    if (f0 && q0.size() > 0) void'(q0.pop_front());
    if (f1 && q1.size() > 0) void'(q1.pop_front());
    drive_srcs();
  end

  always @(negedge clk) begin
    if (rst_n && bus.ob_tvalid && bus.ob_tready)
      out_q.push_back('{strb: bus.ob_tstrb, user: bus.ob_tuser, last: bus.ob_tlast, data: bus.ob_tdata[31:0]});
    if (frame_done_stb) stb_q.push_back(frame_done_src);
    if (watch_mid && q1.size() > 0 && bus.ib0_tready) mid_ib0++;
    if (watch_mid && bus.ob_tvalid && !bus.ob_tready && !bus.ib1_tready) saw_bp++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] ord;
    logic [3:0] pat;

    bus.ob_tready  = 1'b1;
    cfg_ib0_weight = 4'd3;
    halt_i         = 1'b0;
    drive_srcs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ob_tvalid", 64'(bus.ob_tvalid), 64'd0);
    chk("rst_ob_tdata", bus.ob_tdata, 64'd0);
    chk("rst_ib_tready", 64'({bus.ib0_tready, bus.ib1_tready}), 64'd0);
    chk("rst_stb", 64'(frame_done_stb), 64'd0);
    chk("rst_halted", 64'(halted_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Lone 4-beat ib0 frame: output appears two cycles after tvalid
    clr();
    push_frame(1'b0, 1, 4);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.ob_tvalid && n < 20);
    chk("t1_latency", 64'(n), 64'd2);
    wait_idle("t1_drain");
    chk("t1_beat_cnt", 64'(out_q.size()), 64'd4);
    chk_frame("t1_beat", 0, 1'b0, 1, 4);
    chk("t1_stb_cnt", 64'(stb_q.size()), 64'd1);
    if (stb_q.size() > 0) chk("t1_stb_src", 64'(stb_q[0]), 64'd0);

    // Weight 3 contention: 0,0,0,1,0,0,0,1
    clr();
    cfg_ib0_weight = 4'd3;
    for (int i = 0; i < 6; i++) push_frame(1'b0, 10 + i, 1);
    for (int i = 0; i < 2; i++) push_frame(1'b1, 20 + i, 1);
    wait_idle("t2_drain");
    chk("t2_frame_cnt", 64'(stb_q.size()), 64'd8);
    ord = '0;
    for (int i = 0; i < 8 && i < stb_q.size(); i++) ord[i] = stb_q[i];
    chk("t2_order", 64'(ord), 64'h88);

    // Weight 0 behaves as 1: strict alternation
    clr();
    cfg_ib0_weight = 4'd0;
    push_frame(1'b0, 30, 1);
    push_frame(1'b0, 31, 1);
    push_frame(1'b1, 32, 1);
    push_frame(1'b1, 33, 1);
    wait_idle("t3_drain");
    chk("t3_frame_cnt", 64'(stb_q.size()), 64'd4);
    ord = '0;
    for (int i = 0; i < 4 && i < stb_q.size(); i++) ord[i] = stb_q[i];
    chk("t3_order", 64'(ord), 64'hA);

    // Backpressure 1,0,0,1 on a 5-beat ib1 frame with ib0 waiting
    clr();
    mid_ib0 = 0;
    saw_bp  = 0;
    push_frame(1'b1, 40, 5);
    n = 0;
    while (!bus.ib1_tready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_ib1_grant", 64'(bus.ib1_tready), 64'd1);
    watch_mid = 1'b1;
    push_frame(1'b0, 41, 1);
    pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      bus.ob_tready = pat[i];
      @(posedge clk); #1;
    end
    bus.ob_tready = 1'b1;
    wait_idle("t4_drain");
    watch_mid = 1'b0;
    chk("t4_beat_cnt", 64'(out_q.size()), 64'd6);
    chk_frame("t4_ib1_beat", 0, 1'b1, 40, 5);
    chk_frame("t4_ib0_beat", 5, 1'b0, 41, 1);
    chk("t4_stb_cnt", 64'(stb_q.size()), 64'd2);
    if (stb_q.size() > 1) chk("t4_stb_src", 64'({stb_q[0], stb_q[1]}), 64'b10);
    chk("t4_bp_seen", 64'(saw_bp > 0), 64'd1);
    chk("t4_no_ib0_mid", 64'(mid_ib0), 64'd0);

    // Reset mid-frame after a contended ib0 grant (wcnt = 1 with weight 1)
    clr();
    cfg_ib0_weight = 4'd1;
    push_frame(1'b0, 50, 4);
    push_frame(1'b1, 51, 1);
    n = 0;
    while (!bus.ob_tvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ob_tvalid", 64'(bus.ob_tvalid), 64'd0);
    chk("t5_ob_tdata", bus.ob_tdata, 64'd0);
    chk("t5_ob_side", 64'({bus.ob_tlast, bus.ob_tuser, bus.ob_tstrb}), 64'd0);
    chk("t5_ib_tready", 64'({bus.ib0_tready, bus.ib1_tready}), 64'd0);
    chk("t5_stb", 64'({frame_done_stb, frame_done_src}), 64'd0);
    q0.delete();
    q1.delete();
    drive_srcs();
    clr();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_frame(1'b0, 52, 1);
    push_frame(1'b1, 53, 1);
    wait_idle("t5_drain");
    chk("t5_frame_cnt", 64'(stb_q.size()), 64'd2);
    if (stb_q.size() > 1) chk("t5_fresh_order", 64'({stb_q[0], stb_q[1]}), 64'b01);

`ifdef CR_OSF_IB_ARB_HALT_EN
    // Halt during an ib0 frame with ib1 pending
    clr();
    push_frame(1'b0, 60, 3);
    n = 0;
    while (!bus.ib0_tready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    halt_i = 1'b1;
    push_frame(1'b1, 61, 2);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_beat_cnt", 64'(out_q.size()), 64'd3);
    chk_frame("t6_ib0_beat", 0, 1'b0, 60, 3);
    chk("t6_halted", 64'(halted_o), 64'd1);
    chk("t6_ib1_held", 64'({bus.ib1_tready, 1'(q1.size() == 2)}), 64'b01);
    halt_i = 1'b0;
    wait_idle("t6_drain");
    chk("t6_stb_cnt", 64'(stb_q.size()), 64'd2);
    if (stb_q.size() > 1) chk("t6_stb_order", 64'({stb_q[0], stb_q[1]}), 64'b01);
    chk_frame("t6_ib1_beat", 3, 1'b1, 61, 2);
    chk("t6_unhalted", 64'(halted_o), 64'd0);
`else
    // Without halt support, halt_i is ignored
    clr();
    halt_i = 1'b1;
    push_frame(1'b0, 70, 2);
    wait_idle("t6_drain");
    chk("t6_beat_cnt", 64'(out_q.size()), 64'd2);
    chk_frame("t6_ib0_beat", 0, 1'b0, 70, 2);
    chk("t6_halted", 64'(halted_o), 64'd0);
    halt_i = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
